// File: rtl/fetch_queue.sv
// Instruction fetch front end. It owns the fetch PC and issues in-order word
// requests to a variable-latency instruction memory. Returned instructions are
// buffered with their PCs in a DEPTH-entry queue and handed downstream over
// valid/ready. Each queue slot is reserved when its request is accepted, so a
// response always has a slot waiting and needs no tag. A redirect flushes the
// queue, and responses still in flight are counted off and discarded.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter logic [63:0] PC_STEP  = 64'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic        alloc;
    logic        filled;
    logic [63:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t        q [DEPTH];
  logic [63:0]   fetch_pc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] fill_ptr;   // oldest allocated entry still waiting for data
  logic [CW-1:0] alloc_cnt;  // allocated entries, filled or not
  logic [CW-1:0] pend_cnt;   // allocated entries still waiting for data
  logic [CW-1:0] drop_cnt;   // stale responses still to be discarded

  entry_t        head;
  logic          has_unfilled;
  logic          issue;
  logic          pop;
  logic          resp_drop;
  logic          resp_fill;
  logic [CW-1:0] inflight;
  logic [CW-1:0] redirect_drop;

  assign head         = q[rd_ptr];
  assign has_unfilled = q[fill_ptr].alloc & ~q[fill_ptr].filled;

  // A slot freed by a pop only becomes available for a request in the next cycle.
  assign imem_req_valid = ~reset & ~redirect_valid & (alloc_cnt < CW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign inst_valid     = head.alloc & head.filled & ~redirect_valid;
  assign inst           = head.inst;
  assign inst_pc        = head.pc;

  assign issue     = imem_req_valid & imem_req_ready;
  assign pop       = inst_valid & inst_ready;
  assign resp_drop = imem_resp_valid & (drop_cnt != '0);
  assign resp_fill = imem_resp_valid & (drop_cnt == '0) & has_unfilled;

  // Responses to discard after a redirect: everything still in flight, less a
  // response that lands in the redirect cycle itself.
  always_comb begin
    // NOTE: give every combinational output a default first so that no path
    // leaves it unassigned and a latch cannot be inferred.
    inflight      = drop_cnt + pend_cnt;
    redirect_drop = inflight;
    if (imem_resp_valid && (inflight != '0)) redirect_drop = inflight - CW'(1);
  end

  // Queue, pointers, counters and fetch PC; redirect overrides issue, fill and pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the entry storage is cleared on reset as well as the flags,
      // so inst and inst_pc come out of reset as 0 rather than as stale data.
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      fetch_pc  <= RESET_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fill_ptr  <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= '0;
    end else if (redirect_valid) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      fetch_pc  <= redirect_pc;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fill_ptr  <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= redirect_drop;
    end else begin
      // NOTE: non-blocking assignments throughout, so every statement here
      // reads the values from the start of the cycle whatever the order.
      // Issue, fill and pop always touch distinct entries.
      if (issue) begin
        q[wr_ptr] <= '{alloc: 1'b1, filled: 1'b0, pc: fetch_pc, inst: 32'd0};
        wr_ptr    <= wr_ptr + PW'(1);
        fetch_pc  <= fetch_pc + PC_STEP;
      end
      if (resp_fill) begin
        q[fill_ptr].inst   <= imem_resp_data;
        q[fill_ptr].filled <= 1'b1;
        fill_ptr           <= fill_ptr + PW'(1);
      end
      if (resp_drop) drop_cnt <= drop_cnt - CW'(1);
      if (pop) begin
        q[rd_ptr] <= '0;
        rd_ptr    <= rd_ptr + PW'(1);
      end
      alloc_cnt <= alloc_cnt + CW'(issue) - CW'(pop);
      pend_cnt  <= pend_cnt + CW'(issue) - CW'(resp_fill);
    end
  end

  // A response with nothing to drop and nothing waiting is an imem protocol error.
  assert property (@(posedge clk) disable iff (reset)
                   imem_resp_valid |-> ((drop_cnt != '0) || has_unfilled))
    else $error("fetch_queue: unexpected imem response");

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue. An imem model returns responses in order after a
// set latency. Expected {pc, inst} pairs are queued when a request is
// accepted and compared when the queue hands an instruction downstream.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'd0), .PC_STEP(64'd4)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
    bit          filled;
  } exp_t;

  typedef struct {
    logic [63:0] addr;
    int          due;
    int          epoch;
  } req_t;

  exp_t        exp_q[$];
  req_t        imem_q[$];
  logic [63:0] popped_pcs[$];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          epoch = 0;
  int          resp_epoch = 0;
  int          issues = 0;
  int          pops = 0;
  logic [63:0] model_pc = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [63:0] addr);
    return addr[31:0] ^ addr[63:32] ^ 32'h1357_9BDF;
  endfunction

  // One clock: check outputs at the falling edge, advance the models, then
  // drive the next imem response just after the rising edge.
  task automatic tick();
    logic  exp_req;
    logic  exp_iv;
    exp_t  e;
    req_t  r;
    @(negedge clk);
    if (reset) begin
      check("rst_req_valid", 64'(imem_req_valid), 64'd0);
      check("rst_inst_valid", 64'(inst_valid), 64'd0);
      check("rst_inst", 64'(inst), 64'd0);
      check("rst_inst_pc", inst_pc, 64'd0);
    end else begin
      exp_req = !redirect_valid && (exp_q.size() < DEPTH);
      exp_iv  = !redirect_valid && (exp_q.size() > 0) && exp_q[0].filled;
      check("req_valid", 64'(imem_req_valid), 64'(exp_req));
      if (exp_req) check("req_addr", imem_req_addr, model_pc);
      check("inst_valid", 64'(inst_valid), 64'(exp_iv));
      if (exp_iv && inst_valid) begin
        check("inst", 64'(inst), 64'(exp_q[0].data));
        check("inst_pc", inst_pc, exp_q[0].pc);
      end
      if (redirect_valid) begin
        exp_q.delete();
        epoch++;
        model_pc = redirect_pc;
      end else begin
        if (exp_iv && inst_ready) begin
          popped_pcs.push_back(inst_pc);
          void'(exp_q.pop_front());
          pops++;
        end
        if (imem_resp_valid && resp_epoch == epoch) begin
          for (int i = 0; i < exp_q.size(); i++) begin
            if (!exp_q[i].filled) begin
              e = exp_q[i];
              e.filled = 1'b1;
              exp_q[i] = e;
              break;
            end
          end
        end
        if (exp_req && imem_req_ready) begin
          exp_q.push_back('{pc: model_pc, data: data_of(model_pc), filled: 1'b0});
          imem_q.push_back('{addr: model_pc, due: cyc + lat, epoch: epoch});
          model_pc = model_pc + 64'd4;
          issues++;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!reset && imem_q.size() > 0 && imem_q[0].due <= cyc) begin
      r = imem_q.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = data_of(r.addr);
      resp_epoch      = r.epoch;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    imem_resp_valid = 1'b0;
    imem_q.delete();
    exp_q.delete();
    epoch++;
    @(posedge clk);
    #1;
    cyc++;
    tick();
    reset = 1'b0;
    model_pc = 64'd0;
    issues = 0;
    pops = 0;
    popped_pcs.delete();
  endtask

  // Stop fetching and let every expected instruction come out, within a budget.
  task automatic drain();
    imem_req_ready = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 60 && (exp_q.size() > 0 || imem_q.size() > 0); i++) tick();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    imem_req_ready = 1'b1;
  endtask

  task automatic do_redirect(input logic [63:0] pc);
    redirect_pc = pc;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;

    // Streaming: 1-cycle imem, always ready.
    do_reset();
    lat = 1;
    tick();
    check("lat_c1_valid", 64'(inst_valid), 64'd0);
    tick();
    check("lat_c2_valid", 64'(inst_valid), 64'd1);
    check("lat_c2_pc", inst_pc, 64'd0);
    repeat (2) tick();
    n = pops;
    repeat (10) tick();
    check("throughput", 64'(pops - n), 64'd10);
    check("first_pc", popped_pcs[0], 64'd0);
    drain();

    // Full queue with downstream stalled.
    do_reset();
    inst_ready = 1'b0;
    repeat (8) tick();
    check("full_issues", 64'(issues), 64'd4);
    check("full_req_valid", 64'(imem_req_valid), 64'd0);
    inst_ready = 1'b1;
    repeat (12) tick();
    check("resume_count", 64'(popped_pcs.size() > 4), 64'd1);
    if (popped_pcs.size() > 4) begin
      check("drain_pc0", popped_pcs[0], 64'h0);
      check("drain_pc3", popped_pcs[3], 64'hC);
      check("resume_pc", popped_pcs[4], 64'h10);
    end
    drain();

    // imem not ready: the address holds.
    do_reset();
    imem_req_ready = 1'b0;
    repeat (3) begin
      tick();
      check("hold_valid", 64'(imem_req_valid), 64'd1);
      check("hold_addr", imem_req_addr, 64'd0);
    end
    imem_req_ready = 1'b1;
    tick();
    check("hold_accepted", 64'(issues), 64'd1);
    check("hold_next_addr", imem_req_addr, 64'd4);
    drain();

    // Redirect with three requests outstanding at 4-cycle latency.
    do_reset();
    lat = 4;
    repeat (3) tick();
    do_redirect(64'h100);
    check("drop_cnt_3", 64'(dut.drop_cnt), 64'd3);
    check("redir_addr", imem_req_addr, 64'h100);
    repeat (6) tick();
    drain();
    check("redir_first_pc_present", 64'(popped_pcs.size() > 0), 64'd1);
    if (popped_pcs.size() > 0) check("redir_first_pc", popped_pcs[0], 64'h100);
    check("drop_cnt_done", 64'(dut.drop_cnt), 64'd0);
    lat = 1;

    // Redirect in a cycle with a response arriving and a head ready to pop.
    do_reset();
    repeat (6) tick();
    n = popped_pcs.size();
    redirect_pc = 64'h2000;
    redirect_valid = 1'b1;
    #1;
    check("redir_resp_here", 64'(imem_resp_valid), 64'd1);
    check("redir_inst_valid", 64'(inst_valid), 64'd0);
    check("redir_req_valid", 64'(imem_req_valid), 64'd0);
    tick();
    redirect_valid = 1'b0;
    check("redir2_addr", imem_req_addr, 64'h2000);
    check("redir2_drop", 64'(dut.drop_cnt), 64'd0);
    repeat (6) tick();
    drain();
    check("redir2_first_present", 64'(popped_pcs.size() > n), 64'd1);
    if (popped_pcs.size() > n) check("redir2_first_pc", popped_pcs[n], 64'h2000);

    // PC wraps past the top of the address space.
    do_reset();
    do_redirect(64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_first_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    check("wrap_addr", imem_req_addr, 64'h0);
    repeat (3) tick();
    drain();
    check("wrap_pops", 64'(popped_pcs.size() >= 2), 64'd1);
    if (popped_pcs.size() >= 2) begin
      check("wrap_pc0", popped_pcs[0], 64'hFFFF_FFFF_FFFF_FFFC);
      check("wrap_pc1", popped_pcs[1], 64'h0);
    end

    // Reset in the middle of traffic.
    repeat (3) tick();
    do_reset();
    check("mid_reset_addr", imem_req_addr, 64'd0);
    repeat (5) tick();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
